// File: rtl/hash_key_pkg.sv
// hash_key_pkg
// Definitions shared by the key-hashing datapath.
//   state_t    : key_crc_feeder FSM states
//   CRC_W      : CRC register width
//   CRC_SEED   : value the CRC stage holds after its reset
//   LANES      : bytes packed into one CRC word
//   finalise() : turns a raw CRC register value into the finished hash
package hash_key_pkg;

  localparam int CRC_W = 32;
  localparam logic [CRC_W-1:0] CRC_SEED = 32'hFFFF_FFFF;
  localparam int LANES = 4;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_WAIT,
    ST_CAPT,
    ST_OUT,
    ST_CLEAR
  } state_t;

  // The CRC is finished by inverting every bit; XOR against the
  // all-ones seed is the same operation.
  function automatic logic [CRC_W-1:0] finalise(input logic [CRC_W-1:0] crc);
    return crc ^ CRC_SEED;
  endfunction

endpackage

// File: rtl/key_crc_feeder.sv
// key_crc_feeder
// Packs a key byte stream little-endian into 32-bit words for the CRC
// stage, re-seeds the CRC between keys and returns the finished bucket
// index together with the key byte length.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid/in_ready: key byte handshake; in_data byte, in_last end of key
//   crc_data, crc_en : word and one-cycle update strobe for the CRC stage
//   crc_clr          : one-cycle re-seed pulse (parent ORs it with rst)
//   crc_val          : current CRC register value from the CRC stage
//   hash_valid/ready : result handshake
//   hash             : low HASH_BITS of the inverted CRC
//   hash_len/hash_ovf: saturating key byte count and its saturation flag
module key_crc_feeder
  import hash_key_pkg::*;
#(
  parameter int HASH_BITS = 20,
  parameter int LEN_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic [CRC_W-1:0]     crc_data,
  output logic                 crc_en,
  output logic                 crc_clr,
  input  logic [CRC_W-1:0]     crc_val,
  output logic                 hash_valid,
  input  logic                 hash_ready,
  output logic [HASH_BITS-1:0] hash,
  output logic [LEN_W-1:0]     hash_len,
  output logic                 hash_ovf
);

  state_t               r_state;
  state_t               w_next;
  logic [LANE_W-1:0]    r_lane;
  logic [CRC_W-1:0]     r_pack;
  logic [CRC_W-1:0]     r_crc_data;
  logic                 r_crc_en;
  logic                 r_crc_clr;
  logic [LEN_W-1:0]     r_len;
  logic                 r_ovf;
  logic [HASH_BITS-1:0] r_hash;
  logic [LEN_W-1:0]     r_hash_len;
  logic                 r_hash_ovf;

  logic                 w_accept;
  logic                 w_flush;
  logic                 w_len_max;
  logic [CRC_W-1:0]     w_word;
  logic [CRC_W-1:0]     w_fin;
  logic                 w_unused_fin;

  // in_ready comes from the state register only, never from in_valid.
  assign in_ready  = (r_state == ST_FILL);
  assign w_accept  = in_valid && in_ready;
  assign w_flush   = w_accept && ((r_lane == LANE_W'(LANES - 1)) || in_last);
  assign w_len_max = &r_len;
  assign w_fin     = finalise(crc_val);
  // Bits above HASH_BITS are not part of the bucket index.
  assign w_unused_fin = ^w_fin;

  // Current pack register with the incoming byte dropped into its lane.
  always_comb begin
    w_word = r_pack;
    w_word[{r_lane, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FILL:  if (w_accept && in_last) w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_CAPT;
      ST_CAPT:  w_next = ST_OUT;
      ST_OUT:   if (hash_ready) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_FILL;
      default:  w_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane     <= '0;
      r_pack     <= '0;
      r_crc_data <= '0;
      r_crc_en   <= 1'b0;
      r_crc_clr  <= 1'b0;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_hash     <= '0;
      r_hash_len <= '0;
      r_hash_ovf <= 1'b0;
    end else begin
      // Strobe lands in the cycle after the word is captured, so a final
      // word's strobe always falls in WAIT.
      r_crc_en  <= w_flush;
      // Raised on the result handshake so it is high exactly in CLEAR.
      r_crc_clr <= (r_state == ST_OUT) && hash_ready;

      if (w_accept) begin
        if (w_flush) begin
          r_crc_data <= w_word;
          r_pack     <= '0;
        end else begin
          r_pack <= w_word;
        end
        r_lane <= in_last ? '0 : r_lane + LANE_W'(1);
        if (w_len_max) begin
          r_ovf <= 1'b1;
        end else begin
          r_len <= r_len + LEN_W'(1);
        end
      end

      // crc_val already includes the final word here.
      if (r_state == ST_CAPT) begin
        r_hash     <= w_fin[HASH_BITS-1:0];
        r_hash_len <= r_len;
        r_hash_ovf <= r_ovf;
        r_len      <= '0;
        r_ovf      <= 1'b0;
      end
    end
  end

  assign crc_data   = r_crc_data;
  assign crc_en     = r_crc_en;
  assign crc_clr    = r_crc_clr;
  assign hash_valid = (r_state == ST_OUT);
  assign hash       = r_hash;
  assign hash_len   = r_hash_len;
  assign hash_ovf   = r_hash_ovf;

endmodule

// File: tb/tb_key_crc_feeder.sv
module tb_key_crc_feeder;
  import hash_key_pkg::*;

  localparam int HB = 20;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic [31:0]   crc_data;
  logic          crc_en;
  logic          crc_clr;
  logic [31:0]   crc_val;
  logic          hash_valid;
  logic          hash_ready;
  logic [HB-1:0] hash;
  logic [LW-1:0] hash_len;
  logic          hash_ovf;

  always #5 clk = ~clk;

  key_crc_feeder #(.HASH_BITS(HB), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .crc_data(crc_data), .crc_en(crc_en), .crc_clr(crc_clr), .crc_val(crc_val),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .hash(hash),
    .hash_len(hash_len), .hash_ovf(hash_ovf)
  );

  // CRC stage stand-in: reflected CRC-32 over each 32-bit word.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int i = 0; i < 32; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [31:0] stub_q;
  logic        force_en;
  logic [31:0] force_val;
  assign crc_val = force_en ? force_val : stub_q;

  always @(posedge clk or posedge rst) begin
    if (rst)          stub_q <= CRC_SEED;
    else if (crc_clr) stub_q <= CRC_SEED;
    else if (crc_en)  stub_q <= crc_upd(stub_q, crc_data);
  end

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [HB-1:0] h;
    logic [LW-1:0] len;
    logic          ovf;
    logic [7:0]    nw;
  } res_t;

  logic [31:0] exp_words[$];
  res_t        exp_res[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected words go straight to the scoreboard; returns the expected result.
  function automatic res_t model_key(input bq_t b);
    logic [31:0] w;
    logic [31:0] c;
    res_t        r;
    w = '0;
    c = CRC_SEED;
    r = '0;
    for (int i = 0; i < b.size(); i++) begin
      w[8*(i%4) +: 8] = b[i];
      if ((i % 4) == 3 || i == b.size() - 1) begin
        exp_words.push_back(w);
        c = crc_upd(c, w);
        r.nw = r.nw + 8'd1;
        w = '0;
      end
    end
    c = ~c;
    r.h   = c[HB-1:0];
    r.ovf = (b.size() > 15);
    r.len = r.ovf ? 4'd15 : LW'(b.size());
    return r;
  endfunction

  // Monitor: checks every CRC word and every consumed result.
  res_t mon_e;
  int   mon_en_cnt = 0;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      mon_en_cnt = 0;
    end else begin
      if (crc_en || crc_clr) chk("en_clr_exclusive", {31'd0, crc_en & crc_clr}, 32'd0);
      if (crc_en) begin
        mon_en_cnt++;
        if (exp_words.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL crc_en_unexpected: observed crc_en=1 data 0x%08h expected no strobe", crc_data);
        end else begin
          chk("crc_data", crc_data, exp_words.pop_front());
        end
      end
      if (hash_valid && hash_ready) begin
        if (exp_res.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL result_unexpected: observed hash 0x%05h expected no result", hash);
        end else begin
          mon_e = exp_res.pop_front();
          chk("hash", 32'(hash), 32'(mon_e.h));
          chk("hash_len", 32'(hash_len), 32'(mon_e.len));
          chk("hash_ovf", 32'(hash_ovf), 32'(mon_e.ovf));
          chk("en_per_key", mon_en_cnt, 32'(mon_e.nw));
        end
        mon_en_cnt = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] d, input logic last, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (in_ready !== 1'b1 && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_errors++;
      $error("FAIL accept_timeout: observed in_ready=%b expected 1 within 64 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_key(input bq_t b, output int first_wait);
    int w;
    first_wait = 0;
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], (i == b.size() - 1), w);
      if (i == 0) first_wait = w;
    end
  endtask

  task automatic wait_result();
    int n = 0;
    while (exp_res.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("result_drained", exp_res.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t  key;
    bq_t  key2;
    res_t e;
    int   w;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    hash_ready = 1'b0; force_en = 1'b0; force_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_crc_data", crc_data, 32'd0);
    chk("rst_crc_en", {31'd0, crc_en}, 32'd0);
    chk("rst_crc_clr", {31'd0, crc_clr}, 32'd0);
    chk("rst_hash_valid", {31'd0, hash_valid}, 32'd0);
    chk("rst_hash", 32'(hash), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single word, hash from a fixed crc_val at CAPT.
    key = '{8'h11, 8'h22, 8'h33, 8'h44};
    e = model_key(key);
    e.h = 20'hBA987;
    exp_res.push_back(e);
    send_key(key, w);
    chk("t1_en_T1", {31'd0, crc_en}, 32'd1);
    chk("t1_data_T1", crc_data, 32'h44332211);
    chk("t1_ready_T1", {31'd0, in_ready}, 32'd0);
    force_en = 1'b1;
    force_val = 32'h12345678;
    @(negedge clk);
    chk("t1_en_T2", {31'd0, crc_en}, 32'd0);
    chk("t1_valid_T2", {31'd0, hash_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid_T3", {31'd0, hash_valid}, 32'd1);
    chk("t1_hash_T3", 32'(hash), 32'h000BA987);
    chk("t1_len_T3", 32'(hash_len), 32'd4);
    force_en = 1'b0;
    hash_ready = 1'b1;
    wait_result();
    @(negedge clk);

    // Partial word plus result backpressure.
    hash_ready = 1'b0;
    key = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    e = model_key(key);
    exp_res.push_back(e);
    send_key(key, w);
    chk("t2_en_last", {31'd0, crc_en}, 32'd1);
    chk("t2_data_last", crc_data, 32'h000000EE);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, hash_valid}, 32'd1);
      chk("bp_hash", 32'(hash), 32'(e.h));
      chk("bp_len", 32'(hash_len), 32'd5);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_crc_clr", {31'd0, crc_clr}, 32'd0);
      @(negedge clk);
    end
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
    chk("bp_clr_H1", {31'd0, crc_clr}, 32'd1);
    chk("bp_ready_H1", {31'd0, in_ready}, 32'd0);
    chk("bp_valid_H1", {31'd0, hash_valid}, 32'd0);
    @(negedge clk);
    chk("bp_clr_H2", {31'd0, crc_clr}, 32'd0);
    chk("bp_ready_H2", {31'd0, in_ready}, 32'd1);
    chk("bp_drained", exp_res.size(), 32'd0);

    // Back-to-back 8-byte keys at full rate.
    hash_ready = 1'b1;
    key.delete();
    key2.delete();
    for (int i = 0; i < 8; i++) begin
      key.push_back(8'(8'h10 + i * 3));
      key2.push_back(8'(8'hC0 ^ (i * 17)));
    end
    e = model_key(key);
    exp_res.push_back(e);
    send_key(key, w);
    e = model_key(key2);
    exp_res.push_back(e);
    send_key(key2, w);
    chk("b2b_first_accept_wait", w, 32'd4);
    wait_result();
    @(negedge clk);

    // Length saturation: 20 bytes with a 4-bit counter.
    key.delete();
    for (int i = 0; i < 20; i++) key.push_back(8'(i * 7 + 3));
    e = model_key(key);
    chk("sat_model_len", 32'(e.len), 32'd15);
    exp_res.push_back(e);
    send_key(key, w);
    wait_result();
    @(negedge clk);

    // Reset part-way through a key, then a normal key.
    send_byte(8'h01, 1'b0, w);
    send_byte(8'h02, 1'b0, w);
    send_byte(8'h03, 1'b0, w);
    rst = 1'b1;
    #1;
    chk("mid_rst_crc_data", crc_data, 32'd0);
    chk("mid_rst_crc_en", {31'd0, crc_en}, 32'd0);
    chk("mid_rst_crc_clr", {31'd0, crc_clr}, 32'd0);
    chk("mid_rst_valid", {31'd0, hash_valid}, 32'd0);
    chk("mid_rst_hash", 32'(hash), 32'd0);
    chk("mid_rst_len", 32'(hash_len), 32'd0);
    chk("mid_rst_ovf", {31'd0, hash_ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    key = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    e = model_key(key);
    exp_res.push_back(e);
    send_key(key, w);
    chk("post_rst_data", crc_data, 32'h8D7C6B5A);
    wait_result();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_crc_feeder.md
# key_crc_feeder

Upstream feeder for the 32-bit CRC hash stage. It accepts a key as a byte stream with valid/ready/last and packs the bytes little-endian into 32-bit words. It drives the CRC stage's data and enable, re-seeds the CRC between keys, and returns the finalised hash index and key length on a valid/ready output. It sits between the request parser and the hash-table lookup in the KV datapath.

## Interface
- HASH_BITS, 20, width of the emitted bucket index (1..32).
- LEN_W, 8, width of the key byte-length counter.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  key byte valid.
- in_ready  out  1  key byte accepted when in_valid && in_ready.
- in_data  in  8  key byte.
- in_last  in  1  marks the final byte of the key.
- crc_data  out  32  word for the CRC stage's data input.
- crc_en  out  1  one-cycle CRC update strobe.
- crc_clr  out  1  registered one-cycle re-seed pulse. Parent ORs it with rst into the CRC stage's reset, which seeds all-ones.
- crc_val  in  32  CRC stage's current register value.
- hash_valid  out  1  result valid.
- hash_ready  in  1  result consumed when hash_valid && hash_ready.
- hash  out  HASH_BITS  equals (~crc_val)[HASH_BITS-1:0], captured after the final word.
- hash_len  out  LEN_W  key length in bytes, saturating.
- hash_ovf  out  1  length saturated.

## Operation
- States: FILL, WAIT, CAPT, OUT, CLEAR. Reset enters FILL. The CRC stage is already seeded by rst, so no CLEAR is needed after reset.
- **FILL:**
  - in_ready=1.
  - An accepted byte goes into lane lane_cnt (byte 0 → bits 7:0). lane_cnt increments mod 4.
  - On accept with lane_cnt==3 or in_last, the packed word moves to the crc_data register. Lanes not yet written are zero. crc_en=1 in the next cycle.
  - The pack register clears, so the next byte may be accepted in that same next cycle.
  - On accept with in_last, go to WAIT.
- **WAIT:** in_ready=0; crc_en is high for the final word in this cycle.
- **CAPT:** crc_val now includes the final word. Latch hash, hash_len, hash_ovf.
- **OUT:** hash_valid=1 and all result outputs held stable until hash_ready. On handshake go to CLEAR.
- **CLEAR:** crc_clr=1 for exactly one cycle, in_ready=0, then FILL.
- **Length:** counts accepted bytes of the current key. It saturates at 2^LEN_W−1 and sets hash_ovf; hashing continues over all bytes.
- **Word boundaries:**
  - A key of length 4k produces exactly k crc_en pulses, with no trailing zero word.
  - A key of length 4k+r (r=1..3) produces k+1 pulses; the last word is zero-padded above r bytes.
- crc_en is never asserted outside FILL-issued words. crc_en and crc_clr are never high in the same cycle.
- in_ready does not depend combinationally on in_valid.
- **Reset mid-key or mid-OUT:** the partial key and any pending result are discarded. Return to FILL with reset values.
- **Reset values:** crc_data=0, crc_en=0, crc_clr=0, hash_valid=0, hash=0, hash_len=0, hash_ovf=0. in_ready=1 once rst deasserts (FILL).

## Timing
- Final byte accepted in cycle T:
  - T+1: WAIT, crc_en=1.
  - T+2: CAPT.
  - T+3: hash_valid=1.
- Handshake in cycle H: H+1 is CLEAR (crc_clr=1). H+2 is FILL, the earliest next-key byte.
- Full-rate bytes give one crc_en every 4 cycles. There are no stalls inside a key.
- hash_ready held low: OUT persists indefinitely and in_ready stays 0.

## Structure
- Shared package hash_key_pkg holds:
  - the state enum;
  - CRC_W=32;
  - CRC_SEED=32'hFFFF_FFFF;
  - the byte-lane count of 4.
- No sub-module is required. The CRC stage is instantiated by the parent next to this block, with its reset = rst | crc_clr.
- Verification may substitute a crc_val stub.

## Test plan
- **Single word:**
  - Stimulus: bytes 11,22,33,44 (last on 44).
  - One crc_en, at the cycle after the 44 accept, with crc_data=0x44332211.
  - Stub crc_val=0x12345678 at CAPT gives hash=0xBA987, hash_len=4, hash_valid at T+3.
- **Partial word:**
  - Stimulus: 5-byte key AA,BB,CC,DD,EE.
  - Two crc_en pulses, crc_data 0xDDCCBBAA then 0x000000EE; hash_len=5.
- **Backpressure:**
  - hash_ready low for 10 cycles keeps hash_valid, hash and hash_len stable, in_ready=0 and crc_clr=0.
  - On release: crc_clr pulses once at H+1, and in_ready returns at H+2.
- **Back-to-back keys:**
  - Two 8-byte keys at full rate; the second key's first byte is accepted at H+2.
  - crc_clr precedes the second key's first crc_en.
  - Exactly 2 crc_en per key.
- **Length saturation:** with LEN_W=4, a 20-byte key gives hash_len=15, hash_ovf=1 and 5 crc_en pulses.
- **Reset mid-key:**
  - Assert rst after 3 bytes: all outputs go to reset values and no crc_en is issued for the partial word.
  - A following 4-byte key hashes normally.
